// File: rtl/i2c_slave_controller.sv
// I2C slave transaction sequencer: START/STOP detection, address phase handshake with the
// decoder, ACK generation, and byte transfer to/from the register side.
module i2c_slave_controller #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       FPGA_clk,
   input  logic       rst,
   input  logic       SCL,
   input  logic       SDA,
   output logic       sda_pull_low,
   output logic       addr_enable,
   input  logic       addr_done,
   input  logic       addr_selected,
   output logic       busy,
   output logic       rw,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_req
);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StWrData,
      StWrAck,
      StRdData,
      StRdAck,
      StWaitStop
   } state_e;

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s, sda_s;
   logic                   scl_q, sda_q;

   // Synchronisers are left unreset so that reset never fabricates bus edges.
   always_ff @(posedge FPGA_clk) begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
   end

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   logic scl_rise, scl_fall, start_det, stop_det;

   assign scl_rise  = scl_s & ~scl_q;
   assign scl_fall  = ~scl_s & scl_q;
   assign start_det = scl_s & sda_q & ~sda_s;
   assign stop_det  = scl_s & ~sda_q & sda_s;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [6:0] shift_q, shift_d;
   logic       rw_q, rw_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       pull_q, pull_d;
   logic       addr_en_q, addr_en_d;
   logic       busy_q, busy_d;
   logic       sel_q, sel_d;
   logic       load_tx;

   always_ff @(posedge FPGA_clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         shift_q    <= 7'd0;
         rw_q       <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         pull_q     <= 1'b0;
         addr_en_q  <= 1'b0;
         busy_q     <= 1'b0;
         sel_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         rw_q       <= rw_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         pull_q     <= pull_d;
         addr_en_q  <= addr_en_d;
         busy_q     <= busy_d;
         sel_q      <= sel_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      rw_d       = rw_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      pull_d     = pull_q;
      addr_en_d  = addr_en_q;
      busy_d     = busy_q;
      sel_d      = sel_q;
      load_tx    = 1'b0;

      if (scl_rise && state_q != StIdle && state_q != StWaitStop) begin
         cnt_d = cnt_q + 4'd1;
      end

      case (state_q)
         StIdle: begin
         end
         StAddr: begin
            if (addr_done && addr_selected) begin
               sel_d = 1'b1;
            end
            if (scl_rise) begin
               shift_d = {shift_q[5:0], sda_s};
               if (cnt_q == 4'd7) begin
                  rw_d = sda_s;
               end
            end
            if (scl_fall && cnt_q == 4'd8) begin
               addr_en_d = 1'b0;
               if (sel_d) begin
                  state_d = StAddrAck;
                  pull_d  = 1'b1;
               end else begin
                  state_d = StWaitStop;
               end
            end
         end
         StAddrAck: begin
            if (scl_fall && cnt_q == 4'd9) begin
               cnt_d = 4'd0;
               if (rw_q) begin
                  load_tx = 1'b1;
               end else begin
                  state_d = StWrData;
                  pull_d  = 1'b0;
               end
            end
         end
         StWrData: begin
            if (scl_rise) begin
               shift_d = {shift_q[5:0], sda_s};
               if (cnt_q == 4'd7) begin
                  rx_data_d  = {shift_q, sda_s};
                  rx_valid_d = 1'b1;
               end
            end
            if (scl_fall && cnt_q == 4'd8) begin
               state_d = StWrAck;
               pull_d  = 1'b1;
            end
         end
         StWrAck: begin
            if (scl_fall && cnt_q == 4'd9) begin
               cnt_d   = 4'd0;
               pull_d  = 1'b0;
               state_d = StWrData;
            end
         end
         StRdData: begin
            // The fall at count 0 is the one that loaded the byte; bit 7 is already driven.
            if (scl_fall && cnt_q == 4'd8) begin
               pull_d  = 1'b0;
               state_d = StRdAck;
            end else if (scl_fall && cnt_q != 4'd0) begin
               pull_d  = ~shift_q[6];
               shift_d = {shift_q[5:0], 1'b0};
            end
         end
         StRdAck: begin
            if (scl_rise && cnt_q == 4'd8 && sda_s) begin
               state_d = StWaitStop;
            end
            if (scl_fall && cnt_q == 4'd9) begin
               cnt_d   = 4'd0;
               load_tx = 1'b1;
            end
         end
         StWaitStop: begin
         end
         default: state_d = StIdle;
      endcase

      if (load_tx) begin
         state_d = StRdData;
         shift_d = tx_data[6:0];
         pull_d  = ~tx_data[7];
      end

      // STOP wins over START if a malformed bus ever produces both at once.
      if (stop_det) begin
         state_d    = StIdle;
         cnt_d      = 4'd0;
         rx_data_d  = rx_data_q;
         rx_valid_d = 1'b0;
         pull_d     = 1'b0;
         addr_en_d  = 1'b0;
         busy_d     = 1'b0;
         load_tx    = 1'b0;
      end else if (start_det) begin
         state_d    = StAddr;
         cnt_d      = 4'd0;
         rx_data_d  = rx_data_q;
         rx_valid_d = 1'b0;
         pull_d     = 1'b0;
         addr_en_d  = 1'b1;
         busy_d     = 1'b1;
         sel_d      = 1'b0;
         load_tx    = 1'b0;
      end
   end

   assign sda_pull_low = pull_q;
   assign addr_enable  = addr_en_q;
   assign busy         = busy_q;
   assign rw           = rw_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   // tx_data is captured on the same edge that ends this strobe.
   assign tx_req       = load_tx & ~rst;

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Directed bench for i2c_slave_controller: a bit-banged I2C master and decoder stub drive
// the pins; a table of write transactions plus hand-written read/Sr/STOP/reset sequences.
module tb_i2c_slave_controller;

   logic       clk;
   logic       rst;
   logic       scl_m, sda_m;
   logic       sda_bus;
   logic       sda_pull_low, addr_enable, addr_done, addr_selected;
   logic       busy, rw, rx_valid, tx_req;
   logic [7:0] rx_data, tx_data;

   assign sda_bus = sda_m & ~sda_pull_low;

   i2c_slave_controller #(.SYNC_STAGES(2)) dut (
      .FPGA_clk      (clk),
      .rst           (rst),
      .SCL           (scl_m),
      .SDA           (sda_bus),
      .sda_pull_low  (sda_pull_low),
      .addr_enable   (addr_enable),
      .addr_done     (addr_done),
      .addr_selected (addr_selected),
      .busy          (busy),
      .rw            (rw),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .tx_data       (tx_data),
      .tx_req        (tx_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int rx_cnt = 0;
   int tx_cnt = 0;

   always @(negedge clk) begin
      if (rx_valid) rx_cnt <= rx_cnt + 1;
      if (tx_req)   tx_cnt <= tx_cnt + 1;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One SCL period starting and ending with SCL low; returns the line seen mid-high.
   task automatic clk_bit(input logic b, output logic seen);
      sda_m = b;
      wait_cyc(5);
      scl_m = 1'b1;
      wait_cyc(5);
      seen = sda_bus;
      wait_cyc(5);
      scl_m = 1'b0;
      wait_cyc(5);
   endtask

   task automatic do_start();
      sda_m = 1'b0;
      wait_cyc(10);
      scl_m = 1'b0;
      wait_cyc(5);
   endtask

   task automatic do_rstart();
      sda_m = 1'b1;
      wait_cyc(5);
      scl_m = 1'b1;
      wait_cyc(5);
      sda_m = 1'b0;
      wait_cyc(5);
      scl_m = 1'b0;
      wait_cyc(5);
   endtask

   task automatic do_stop();
      sda_m = 1'b0;
      wait_cyc(5);
      scl_m = 1'b1;
      wait_cyc(5);
      sda_m = 1'b1;
      wait_cyc(10);
   endtask

   // Address byte with a one-cycle decoder pulse before the 8th bit; returns the ACK line.
   task automatic send_addr(input logic [7:0] a, input logic sel, output logic ack_line);
      logic junk;
      for (int i = 7; i >= 1; i--) clk_bit(a[i], junk);
      addr_done     = 1'b1;
      addr_selected = sel;
      wait_cyc(1);
      addr_done     = 1'b0;
      addr_selected = 1'b0;
      clk_bit(a[0], junk);
      clk_bit(1'b1, ack_line);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack_line);
      logic junk;
      for (int i = 7; i >= 0; i--) clk_bit(d[i], junk);
      clk_bit(1'b1, ack_line);
   endtask

   task automatic read_byte(output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, b);
         d[i] = b;
      end
   endtask

   typedef struct {
      logic [7:0] addr_byte;
      logic       sel;
      logic [7:0] data;
      logic       exp_ack_line;
      logic [7:0] exp_rx;
      int         exp_pulses;
   } wvec_t;

   wvec_t vecs[4];

   initial begin
      logic       line;
      logic [7:0] rd;
      int         rx0, tx0;

      vecs[0] = '{8'h10, 1'b1, 8'hA5, 1'b0, 8'hA5, 1};
      vecs[1] = '{8'h12, 1'b0, 8'h5A, 1'b1, 8'hA5, 0};
      vecs[2] = '{8'h10, 1'b1, 8'h00, 1'b0, 8'h00, 1};
      vecs[3] = '{8'h10, 1'b1, 8'hFF, 1'b0, 8'hFF, 1};

      rst = 1'b1;
      scl_m = 1'b1;
      sda_m = 1'b1;
      addr_done = 1'b0;
      addr_selected = 1'b0;
      tx_data = 8'h00;
      wait_cyc(5);
      check("reset_pull", sda_pull_low, 0);
      check("reset_addr_enable", addr_enable, 0);
      check("reset_busy", busy, 0);
      check("reset_rw", rw, 0);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_tx_req", tx_req, 0);
      rst = 1'b0;
      wait_cyc(5);

      for (int i = 0; i < 4; i++) begin
         rx0 = rx_cnt;
         do_start();
         check($sformatf("v%0d_busy_start", i), busy, 1);
         check($sformatf("v%0d_addr_enable_on", i), addr_enable, 1);
         send_addr(vecs[i].addr_byte, vecs[i].sel, line);
         check($sformatf("v%0d_addr_ack_line", i), line, vecs[i].exp_ack_line);
         check($sformatf("v%0d_addr_enable_off", i), addr_enable, 0);
         check($sformatf("v%0d_rw", i), rw, 0);
         send_byte(vecs[i].data, line);
         check($sformatf("v%0d_data_ack_line", i), line, vecs[i].exp_ack_line);
         check($sformatf("v%0d_rx_pulses", i), rx_cnt - rx0, vecs[i].exp_pulses);
         check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx);
         do_stop();
         check($sformatf("v%0d_busy_stop", i), busy, 0);
         check($sformatf("v%0d_pull_stop", i), sda_pull_low, 0);
      end

      // Two-byte read: ACK the first, NACK the second.
      tx_data = 8'h3C;
      tx0 = tx_cnt;
      do_start();
      send_addr(8'h11, 1'b1, line);
      check("rd_addr_ack_line", line, 0);
      check("rd_rw", rw, 1);
      read_byte(rd);
      check("rd_byte1", rd, 8'h3C);
      tx_data = 8'hC3;
      clk_bit(1'b0, line);
      read_byte(rd);
      check("rd_byte2", rd, 8'hC3);
      clk_bit(1'b1, line);
      check("rd_nack_line", line, 1);
      check("rd_pull_released", sda_pull_low, 0);
      check("rd_tx_req_count", tx_cnt - tx0, 2);
      do_stop();
      check("rd_busy_stop", busy, 0);

      // Write address, then repeated START into a read.
      tx_data = 8'h3C;
      do_start();
      send_addr(8'h10, 1'b1, line);
      check("sr_rw_first", rw, 0);
      do_rstart();
      check("sr_addr_enable", addr_enable, 1);
      check("sr_busy", busy, 1);
      tx0 = tx_cnt;
      for (int i = 7; i >= 1; i--) clk_bit(1'b0, line);
      addr_done = 1'b1;
      addr_selected = 1'b1;
      wait_cyc(1);
      addr_done = 1'b0;
      addr_selected = 1'b0;
      clk_bit(1'b1, line);
      check("sr_rw_second", rw, 1);
      check("sr_no_early_tx_req", tx_cnt - tx0, 0);
      clk_bit(1'b1, line);
      check("sr_ack_line", line, 0);
      check("sr_tx_req_at_ack_fall", tx_cnt - tx0, 1);
      read_byte(rd);
      check("sr_read_byte", rd, 8'h3C);
      clk_bit(1'b1, line);
      do_stop();
      check("sr_busy_stop", busy, 0);

      // STOP after four data bits of 0xF0.
      rx0 = rx_cnt;
      do_start();
      send_addr(8'h10, 1'b1, line);
      for (int i = 0; i < 4; i++) clk_bit(1'b1, line);
      do_stop();
      check("mid_rx_pulses", rx_cnt - rx0, 0);
      check("mid_rx_data", rx_data, 8'hFF);
      check("mid_busy", busy, 0);
      check("mid_pull", sda_pull_low, 0);

      // Reset in the middle of a read byte.
      tx_data = 8'h3C;
      tx0 = tx_cnt;
      do_start();
      send_addr(8'h11, 1'b1, line);
      for (int i = 0; i < 4; i++) clk_bit(1'b1, line);
      check("rstmid_rw_before", rw, 1);
      rst = 1'b1;
      wait_cyc(1);
      check("rstmid_pull", sda_pull_low, 0);
      check("rstmid_addr_enable", addr_enable, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_rw", rw, 0);
      check("rstmid_rx_data", rx_data, 8'h00);
      check("rstmid_rx_valid", rx_valid, 0);
      check("rstmid_tx_req", tx_req, 0);
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(3);
      do_stop();
      check("rstmid_stop_busy", busy, 0);
      check("rstmid_stop_pull", sda_pull_low, 0);
      check("rstmid_tx_count", tx_cnt - tx0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_slave_controller.md
# i2c_slave_controller

Transaction sequencer for the I2C slave. It detects START and STOP on the bus and enables the address decoder for the address phase. It drives the slave's ACK and read data onto SDA through an open-drain pull-low output, and moves data bytes to and from the register side through simple valid/request strobes. It sits between the bus pins (SCL/SDA) and the address decoder plus the slave register file.

## Interface
Parameters:
- SYNC_STAGES, 2: number of flops in the SCL/SDA synchronisers (minimum 2).

Ports (single clock domain):
- FPGA_clk  in  1  system clock; all logic on its rising edge. Period ≤ 1/16 of the SCL period.
- rst  in  1  synchronous, active-high reset.
- SCL  in  1  raw bus clock; synchronised internally.
- SDA  in  1  raw bus data; synchronised internally.
- sda_pull_low  out  1  1 = pull SDA low (open-drain); 0 = release.
- addr_enable  out  1  enables the address decoder for the address phase.
- addr_done  in  1  decoder finished comparing (1-cycle pulse or level).
- addr_selected  in  1  decoder match result; valid when addr_done = 1.
- busy  out  1  high from START to STOP.
- rw  out  1  R/W bit of the current transfer (1 = read); held until the next START.
- rx_data  out  8  last byte written by the master.
- rx_valid  out  1  1-cycle strobe; rx_data is valid.
- tx_data  in  8  byte to return to the master; sampled in the cycle tx_req = 1.
- tx_req  out  1  1-cycle strobe requesting and loading tx_data.

## Operation
- Synchronisers: SCL_s and SDA_s, each SYNC_STAGES flops, plus a one-cycle-delayed copy of each.
- Edge events:
  - scl_rise = SCL_s & ~SCL_q; scl_fall = ~SCL_s & SCL_q.
  - START = SDA_s falls while SCL_s = 1.
  - STOP = SDA_s rises while SCL_s = 1.
- bit_cnt: 4 bits, counts scl_rise within a byte (0..9). It is cleared on START and at every byte boundary.
- States:
  - IDLE: waits for START.
  - ADDR: addr_enable = 1. Shifts SDA on scl_rise. At the 8th scl_rise, rw takes the sampled bit.
    - If addr_done = 1 with addr_selected = 1 at any point before the 8th scl_fall, the result is latched as selected.
    - At the 8th scl_fall, addr_enable drops. Selected → ADDR_ACK with sda_pull_low = 1. Not selected (or addr_done never seen) → WAIT_STOP.
  - ADDR_ACK: holds the pull through the 9th SCL high. At the 9th scl_fall:
    - rw = 0 → WR_DATA, SDA released.
    - rw = 1 → RD_DATA; tx_req pulses in the same cycle, tx_data loads into the shift register, and sda_pull_low = ~tx_data[7].
  - WR_DATA: samples SDA MSB-first on scl_rise. At the 8th scl_rise, rx_data updates and rx_valid pulses. At the 8th scl_fall → WR_ACK with sda_pull_low = 1.
  - WR_ACK: at the 9th scl_fall, releases SDA and returns to WR_DATA for the next byte.
  - RD_DATA: on each scl_fall, shifts left and sets sda_pull_low = ~next bit. At the 8th scl_fall, releases SDA → RD_ACK.
  - RD_ACK: samples SDA at the 9th scl_rise.
    - Low (master ACK): at the 9th scl_fall → RD_DATA with a new tx_req and load, as at ADDR_ACK exit.
    - High (NACK) → WAIT_STOP.
  - WAIT_STOP: SDA released; ignores the bus until START or STOP.
- Global overrides, from any state:
  - STOP → IDLE, SDA released, busy = 0.
  - START (including a repeated START) → ADDR, bit_cnt = 0, SDA released, busy = 1.
  - START and STOP cannot coincide. If a malformed bus produces both in one cycle, STOP takes priority.
- sda_pull_low changes only on scl_fall or START/STOP, never while SCL_s = 1.

## Timing
- Reset values: sda_pull_low = 0, addr_enable = 0, busy = 0, rw = 0, rx_data = 0x00, rx_valid = 0, tx_req = 0; state = IDLE; bit_cnt = 0.
- Pin-to-event latency: SYNC_STAGES+1 FPGA_clk cycles after the raw pin change.
- Output registers update on the FPGA_clk edge after the event cycle; sda_pull_low is registered.
- rx_valid and tx_req are exactly 1 cycle wide; one rx_valid per completed write byte and one tx_req per read byte.
- addr_enable rises in the cycle after START is detected and falls in the cycle after the 8th scl_fall.
- Reset mid-transaction: the cycle after rst = 1, all outputs are at their reset values, and the transfer is abandoned. After rst drops, the block waits in IDLE for a fresh START; a STOP alone does nothing.
- A STOP mid-byte discards the partial byte: no rx_valid, rx_data unchanged.

## Test plan
- Write to a matching address: START, address 0x08 with W; decoder returns done/selected; data 0xA5, then STOP.
  - ACK pulled during the 9th SCL of both bytes.
  - rx_valid pulses once with rx_data = 0xA5.
  - busy falls after STOP.
- Non-matching address: address 0x09 with decoder selected = 0.
  - SDA never pulled; state WAIT_STOP; no rx_valid.
  - After STOP, busy = 0.
- Read of two bytes: address 0x08 with R; tx_data = 0x3C, then 0xC3; master ACKs byte 1 and NACKs byte 2.
  - Exactly 2 tx_req pulses.
  - SDA bit pattern 00111100 then 11000011 (pull = inverted bit).
  - SDA released after the NACK.
- Repeated START: write 0x08 with W, then Sr with 0x08 and R.
  - rw goes 0 → 1; addr_enable re-asserts.
  - First tx_req occurs at the 9th scl_fall of the second address.
- STOP mid-byte: write 0x08, send 4 data bits of 0xF0, then STOP.
  - No rx_valid; rx_data unchanged; IDLE; sda_pull_low = 0.
- Reset mid-read: rst asserted while driving bit 3 of 0x3C.
  - Next cycle all outputs are at reset values.
  - A following STOP without a START keeps busy = 0.
